oam_port_ctrl: RTL and testbench
================================

// Module: oam_port_ctrl
// PURPOSE
//  Owns the single port of the 256-byte primary OAM RAM and shares it among three requesters:
//  sprite evaluation (read-only, owns the port while rendering), CPU OAMADDR/OAMDATA ($2003/$2004),
//  and OAM DMA ($4014). Contains the DMA sequencer (CPU halt, get/put alignment, 256 copies).
//  Sits between the CPU register decode/bus and the sprite-evaluation block in the PPU.
// PARAMETERS
//  OAM_BYTES  256  primary OAM depth. Fixed; the address is 8 bits and wraps mod 256.
// PORTS
//  clk            in   1   master clock
//  rst_n          in   1   asynchronous reset, active low
//  cpu_clk_en     in   1   CPU tick strobe (one clk wide)
//  rendering      in   1   1 = visible or pre-render line with BG or SP enabled
//  sp_oam_addr    in   8   sprite-eval read address
//  sp_oam_data    out  8   sprite-eval read data (= oam_ram_rdata)
//  reg_wr_oamaddr in   1   CPU write $2003 (one clk, already qualified)
//  reg_wr_oamdata in   1   CPU write $2004
//  reg_wdata      in   8   CPU write data
//  reg_rdata      out  8   $2004 read data (combinational)
//  dma_start      in   1   CPU write $4014
//  dma_page       in   8   source page = high byte of the DMA source address
//  dma_busy       out  1   DMA sequence in progress
//  cpu_halt       out  1   stall the CPU core
//  bus_addr       out  16  DMA source address
//  bus_re         out  1   DMA bus read strobe
//  bus_rdata      in   8   CPU bus read data, valid on the same clk as bus_re
//  oam_ram_addr   out  8   OAM RAM address; the RAM is asynchronous read
//  oam_ram_we     out  1   OAM RAM write enable (one clk)
//  oam_ram_wdata  out  8   OAM RAM write data
//  oam_ram_rdata  in   8   OAM RAM read data
// BEHAVIOUR
//  Reset: oam_addr=0, dma_busy=0, cpu_halt=0, bus_re=0, bus_addr=0, oam_ram_we=0, FSM=IDLE,
//   parity=0. Reset mid-DMA aborts to IDLE with no further writes.
//  parity toggles on every cpu_clk_en tick.
//  Port mux: rendering=1 -> oam_ram_addr=sp_oam_addr; otherwise oam_ram_addr=oam_addr.
//  $2003: oam_addr<=reg_wdata.
//  $2004 write, rendering=0: RAM[oam_addr]<=reg_wdata, then oam_addr+=1.
//  $2004 write, rendering=1: the write is dropped and oam_addr+=4, applied to bits [7:2] only.
//  $2004 read: reg_rdata=oam_ram_rdata, with bits [4:2] forced to 0 when oam_ram_addr[1:0]==2
//   (attribute byte). A read does not increment oam_addr.
//  DMA FSM states IDLE, HALT, ALIGN, READ, WRITE. All transitions occur only on cpu_clk_en.
//   IDLE : dma_start -> HALT, latch dma_page, idx=0. dma_start is ignored when not IDLE.
//   HALT : next state is ALIGN if parity==1, else READ.
//   ALIGN: -> READ.
//   READ : bus_re=1, bus_addr={page,idx}, latch bus_rdata -> WRITE.
//   WRITE: oam_ram_we=1 (rendering=0 only), wdata=latched byte, addr=oam_addr; then oam_addr+=1,
//          idx+=1. When idx wraps 255->0 -> IDLE, else -> READ.
//  cpu_halt=dma_busy=(state!=IDLE), registered. Duration is 513 CPU ticks with parity=0 at start,
//   514 with parity=1.
//  DMA writes that land while rendering=1 are dropped; idx and oam_addr still advance.
//  Priority: DMA beats CPU registers. Any $2003/$2004 write while dma_busy is ignored.
//  After a full DMA, oam_addr equals its pre-DMA value (256 increments, mod 256).
//  bus_re and oam_ram_we are single-clk pulses coincident with cpu_clk_en.
// STRUCTURE
//  Shared ppu package holds: typedef enum oam_dma_state_t {IDLE,HALT,ALIGN,READ,WRITE};
//   localparam OAM_BYTES=256; localparam OAM_ATTR_MASK=8'hE3.
//  Sub-module oam_dma_seq: FSM, parity, idx, page and data latch. It outputs
//   dma_we/dma_wdata/dma_inc to the top, which owns oam_addr and the port mux.
// TESTING
//  1. $2003=0x10, $2004 writes 0xAA,0xBB with rendering=0 -> RAM[0x10]=AA, RAM[0x11]=BB,
//     oam_addr=0x12.
//  2. DMA page 0x02, parity=0, oam_addr=0 -> 513 halted ticks; RAM[i]=mem[0x0200+i]
//     for i=0..255; oam_addr=0.
//  3. Same DMA with parity=1 and oam_addr=0x80 -> 514 ticks; RAM[(0x80+i)&FF]=mem[0x0200+i];
//     oam_addr=0x80.
//  4. rendering=1, oam_addr=0x05, $2004 write 0x55 -> RAM unchanged, oam_addr=0x09;
//     oam_ram_addr follows sp_oam_addr.
//  5. RAM[0x02]=0xFF, $2003=0x02, $2004 read -> reg_rdata=0xE3.
//  6. dma_start mid-DMA, $2004 write while busy, reset at tick 100 -> no restart and no CPU
//     write; after reset all outputs are 0 and FSM=IDLE.

Source files
------------

// File: rtl/oam_port_ctrl_pkg.sv
// Shared definitions for the primary-OAM port controller and its DMA sequencer.
package oam_port_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } oam_dma_state_t;

    localparam int unsigned OAM_BYTES     = 256;
    localparam logic [7:0]  OAM_ATTR_MASK = 8'hE3;

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: CPU halt, get/put alignment and 256 read/write pairs.
// Every state change happens on a CPU tick (cpu_clk_en).
module oam_dma_seq
    import oam_port_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_clk_en,
    input  logic        rendering,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic        bus_re,
    output logic        dma_we,
    output logic [7:0]  dma_wdata,
    output logic        dma_inc
);

    oam_dma_state_t r_state;
    logic           r_parity;
    logic           r_busy;
    logic [7:0]     r_page;
    logic [7:0]     r_idx;
    logic [7:0]     r_data;

    // get/put parity: flips on every CPU tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (cpu_clk_en) begin
            r_parity <= ~r_parity;
        end
    end

    // DMA state machine with registered busy flag, page/index and data latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_page  <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else if (cpu_clk_en) begin
            case (r_state)
                IDLE: begin
                    if (dma_start) begin
                        r_state <= HALT;
                        r_busy  <= 1'b1;
                        r_page  <= dma_page;
                        r_idx   <= '0;
                    end
                end
                HALT: begin
                    r_state <= r_parity ? ALIGN : READ;
                end
                ALIGN: begin
                    r_state <= READ;
                end
                READ: begin
                    r_data  <= bus_rdata;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_idx <= r_idx + 8'd1;
                    if (r_idx == 8'hFF) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= READ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Strobes are gated by the tick so each is exactly one clk wide
    always_comb begin
        bus_re    = cpu_clk_en && (r_state == READ);
        dma_inc   = cpu_clk_en && (r_state == WRITE);
        dma_we    = dma_inc && !rendering;
        bus_addr  = {r_page, r_idx};
        dma_wdata = r_data;
        dma_busy  = r_busy;
        cpu_halt  = r_busy;
    end

endmodule

// File: rtl/oam_port_ctrl.sv
// Primary OAM port owner: arbitrates sprite evaluation, $2003/$2004 and OAM DMA
// onto the single asynchronous-read OAM RAM port.
module oam_port_ctrl
    import oam_port_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_clk_en,
    input  logic        rendering,
    input  logic [7:0]  sp_oam_addr,
    output logic [7:0]  sp_oam_data,
    input  logic        reg_wr_oamaddr,
    input  logic        reg_wr_oamdata,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        dma_busy,
    output logic        cpu_halt,
    output logic [15:0] bus_addr,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  oam_ram_addr,
    output logic        oam_ram_we,
    output logic [7:0]  oam_ram_wdata,
    input  logic [7:0]  oam_ram_rdata
);

    logic [7:0] r_oam_addr;
    logic       w_dma_busy;
    logic       w_dma_we;
    logic       w_dma_inc;
    logic [7:0] w_dma_wdata;
    logic       w_cpu_we;

    oam_dma_seq u_dma_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_clk_en (cpu_clk_en),
        .rendering  (rendering),
        .dma_start  (dma_start),
        .dma_page   (dma_page),
        .bus_rdata  (bus_rdata),
        .dma_busy   (w_dma_busy),
        .cpu_halt   (cpu_halt),
        .bus_addr   (bus_addr),
        .bus_re     (bus_re),
        .dma_we     (w_dma_we),
        .dma_wdata  (w_dma_wdata),
        .dma_inc    (w_dma_inc)
    );

    // OAMADDR: DMA advances it; CPU register writes are locked out while DMA runs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_oam_addr <= '0;
        end else if (w_dma_inc) begin
            r_oam_addr <= r_oam_addr + 8'd1;
        end else if (!w_dma_busy) begin
            if (reg_wr_oamaddr) begin
                r_oam_addr <= reg_wdata;
            end else if (reg_wr_oamdata) begin
                // during rendering the write is dropped and only the sprite index bumps
                if (rendering) begin
                    r_oam_addr[7:2] <= r_oam_addr[7:2] + 6'd1;
                end else begin
                    r_oam_addr <= r_oam_addr + 8'd1;
                end
            end
        end
    end

    // Port mux, write arbitration and $2004 read formatting
    always_comb begin
        w_cpu_we      = reg_wr_oamdata && !w_dma_busy && !rendering;
        oam_ram_addr  = rendering ? sp_oam_addr : r_oam_addr;
        oam_ram_we    = w_dma_we || w_cpu_we;
        oam_ram_wdata = w_dma_we ? w_dma_wdata : reg_wdata;
        sp_oam_data   = oam_ram_rdata;
        dma_busy      = w_dma_busy;
        reg_rdata     = oam_ram_rdata;
        if (oam_ram_addr[1:0] == 2'd2) begin
            reg_rdata = oam_ram_rdata & OAM_ATTR_MASK;
        end
    end

endmodule

// File: tb/tb_oam_port_ctrl.sv
// Directed bench for oam_port_ctrl with a behavioural OAM RAM and CPU bus memory.
module tb_oam_port_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_clk_en = 1'b0;
    logic        rendering = 1'b0;
    logic [7:0]  sp_oam_addr = '0;
    logic [7:0]  sp_oam_data;
    logic        reg_wr_oamaddr = 1'b0;
    logic        reg_wr_oamdata = 1'b0;
    logic [7:0]  reg_wdata = '0;
    logic [7:0]  reg_rdata;
    logic        dma_start = 1'b0;
    logic [7:0]  dma_page = '0;
    logic        dma_busy;
    logic        cpu_halt;
    logic [15:0] bus_addr;
    logic        bus_re;
    logic [7:0]  bus_rdata;
    logic [7:0]  oam_ram_addr;
    logic        oam_ram_we;
    logic [7:0]  oam_ram_wdata;
    logic [7:0]  oam_ram_rdata;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram  [0:255];
    logic [7:0] snap [0:255];

    int unsigned div = 0;
    logic tb_par;
    int we_tick = 0, we_off = 0, re_tick = 0, re_off = 0;

    oam_port_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_clk_en     (cpu_clk_en),
        .rendering      (rendering),
        .sp_oam_addr    (sp_oam_addr),
        .sp_oam_data    (sp_oam_data),
        .reg_wr_oamaddr (reg_wr_oamaddr),
        .reg_wr_oamdata (reg_wr_oamdata),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .dma_start      (dma_start),
        .dma_page       (dma_page),
        .dma_busy       (dma_busy),
        .cpu_halt       (cpu_halt),
        .bus_addr       (bus_addr),
        .bus_re         (bus_re),
        .bus_rdata      (bus_rdata),
        .oam_ram_addr   (oam_ram_addr),
        .oam_ram_we     (oam_ram_we),
        .oam_ram_wdata  (oam_ram_wdata),
        .oam_ram_rdata  (oam_ram_rdata)
    );

    always #5 clk = ~clk;

    // CPU tick: one clk in three
    always @(posedge clk) begin
        #1;
        div = (div == 2) ? 0 : div + 1;
        cpu_clk_en = (div == 0);
    end

    // reference parity, toggled on every tick like the hardware counter
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_par <= 1'b0;
        else if (cpu_clk_en) tb_par <= ~tb_par;
    end

    // asynchronous-read OAM RAM
    always @(posedge clk) begin
        if (oam_ram_we) ram[oam_ram_addr] <= oam_ram_wdata;
    end
    assign oam_ram_rdata = ram[oam_ram_addr];

    function automatic logic [7:0] memf(input logic [15:0] a);
        return ((a[7:0] * 8'd7) ^ a[15:8]) + 8'h3C;
    endfunction
    assign bus_rdata = memf(bus_addr);

    // strobe counters, split by whether they coincide with a tick
    always @(posedge clk) begin
        if (oam_ram_we) begin
            if (cpu_clk_en) we_tick++;
            else we_off++;
        end
        if (bus_re) begin
            if (cpu_clk_en) re_tick++;
            else re_off++;
        end
    end

    task automatic wait_neg_tick();
        int n = 0;
        @(negedge clk);
        while (!cpu_clk_en && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic skip_ticks(input int n);
        repeat (n) begin
            wait_neg_tick();
            @(posedge clk);
        end
    endtask

    task automatic cpu_wr_addr(input logic [7:0] v);
        @(negedge clk);
        reg_wr_oamaddr = 1'b1;
        reg_wdata = v;
        @(negedge clk);
        reg_wr_oamaddr = 1'b0;
    endtask

    task automatic cpu_wr_data(input logic [7:0] v);
        @(negedge clk);
        reg_wr_oamdata = 1'b1;
        reg_wdata = v;
        @(negedge clk);
        reg_wr_oamdata = 1'b0;
    endtask

    task automatic cpu_wr_data_off(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (cpu_clk_en && n < 10) begin
            @(negedge clk);
            n++;
        end
        reg_wr_oamdata = 1'b1;
        reg_wdata = v;
        @(negedge clk);
        reg_wr_oamdata = 1'b0;
    endtask

    // issue dma_start on a tick whose pre-edge parity equals want
    task automatic start_dma(input logic [7:0] page, input logic want);
        int n = 0;
        @(negedge clk);
        while (!(cpu_clk_en && tb_par == want) && n < 20) begin
            @(negedge clk);
            n++;
        end
        dma_start = 1'b1;
        dma_page = page;
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    // returns number of ticks seen with cpu_halt high
    task automatic run_dma(input logic [7:0] page, input logic want, output int halt_ticks);
        int n = 0;
        start_dma(page, want);
        halt_ticks = 0;
        while (cpu_halt && n < 4000) begin
            if (cpu_clk_en) halt_ticks++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        total++;
        if ({dma_busy, cpu_halt, bus_re, oam_ram_we} !== 4'b0 || bus_addr !== 16'h0 || oam_ram_addr !== 8'h00) begin
            bad++;
            $display("FAIL %s: busy=%b halt=%b re=%b we=%b bus_addr=%h ram_addr=%h, required all 0",
                     tag, dma_busy, cpu_halt, bus_re, oam_ram_we, bus_addr, oam_ram_addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_active");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_cpu_write();
        rendering = 1'b0;
        cpu_wr_addr(8'h10);
        cpu_wr_data(8'hAA);
        cpu_wr_data(8'hBB);
        @(negedge clk);
        total++;
        if (ram[8'h10] !== 8'hAA || ram[8'h11] !== 8'hBB) begin
            bad++;
            $display("FAIL cpu_write_data: ram10=%h ram11=%h, required AA BB", ram[8'h10], ram[8'h11]);
        end
        total++;
        if (oam_ram_addr !== 8'h12) begin
            bad++;
            $display("FAIL cpu_write_addr: got %h, required 12", oam_ram_addr);
        end
        cpu_wr_addr(8'hFF);
        cpu_wr_data(8'h22);
        @(negedge clk);
        total++;
        if (ram[8'hFF] !== 8'h22 || oam_ram_addr !== 8'h00) begin
            bad++;
            $display("FAIL cpu_write_wrap: ramFF=%h addr=%h, required 22 00", ram[8'hFF], oam_ram_addr);
        end
    endtask

    task automatic test_dma(input logic want, input logic [7:0] base, input int exp_ticks, input string tag);
        int ht, w0, wo0, r0, ro0, nerr;
        logic [7:0] first_a;
        rendering = 1'b0;
        cpu_wr_addr(base);
        w0 = we_tick; wo0 = we_off; r0 = re_tick; ro0 = re_off;
        run_dma(8'h02, want, ht);
        total++;
        if (ht !== exp_ticks) begin
            bad++;
            $display("FAIL %s_ticks: got %0d, required %0d", tag, ht, exp_ticks);
        end
        total++;
        if (we_tick - w0 !== 256 || re_tick - r0 !== 256 || we_off - wo0 !== 0 || re_off - ro0 !== 0) begin
            bad++;
            $display("FAIL %s_strobes: we=%0d re=%0d we_off=%0d re_off=%0d, required 256 256 0 0",
                     tag, we_tick - w0, re_tick - r0, we_off - wo0, re_off - ro0);
        end
        @(negedge clk);
        nerr = 0;
        first_a = '0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i) + base;
            if (ram[a] !== memf({8'h02, 8'(i)})) begin
                if (nerr == 0) first_a = a;
                nerr++;
            end
        end
        total++;
        if (nerr !== 0) begin
            bad++;
            $display("FAIL %s_ram: %0d bytes wrong, first at %h, required 0 wrong", tag, nerr, first_a);
        end
        total++;
        if (oam_ram_addr !== base || dma_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_end: addr=%h busy=%b, required %h 0", tag, oam_ram_addr, dma_busy, base);
        end
    endtask

    task automatic test_rendering_write();
        int ndiff;
        rendering = 1'b0;
        cpu_wr_addr(8'h05);
        snap = ram;
        rendering = 1'b1;
        sp_oam_addr = 8'h33;
        cpu_wr_data(8'h55);
        @(negedge clk);
        total++;
        if (oam_ram_addr !== 8'h33 || sp_oam_data !== ram[8'h33]) begin
            bad++;
            $display("FAIL render_mux: addr=%h data=%h, required 33 %h", oam_ram_addr, sp_oam_data, ram[8'h33]);
        end
        ndiff = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== snap[i]) ndiff++;
        total++;
        if (ndiff !== 0) begin
            bad++;
            $display("FAIL render_drop: %0d bytes changed, required 0", ndiff);
        end
        rendering = 1'b0;
        @(negedge clk);
        total++;
        if (oam_ram_addr !== 8'h09) begin
            bad++;
            $display("FAIL render_inc4: got %h, required 09", oam_ram_addr);
        end
        cpu_wr_addr(8'hFE);
        rendering = 1'b1;
        cpu_wr_data(8'h11);
        rendering = 1'b0;
        @(negedge clk);
        total++;
        if (oam_ram_addr !== 8'h02 || ram[8'hFE] !== snap[8'hFE]) begin
            bad++;
            $display("FAIL render_inc4_wrap: addr=%h ramFE=%h, required 02 %h", oam_ram_addr, ram[8'hFE], snap[8'hFE]);
        end
    endtask

    task automatic test_dma_rendering();
        int ht, w0, r0, ndiff;
        rendering = 1'b0;
        cpu_wr_addr(8'h20);
        snap = ram;
        w0 = we_tick; r0 = re_tick;
        rendering = 1'b1;
        sp_oam_addr = 8'h00;
        run_dma(8'h03, 1'b1, ht);
        rendering = 1'b0;
        @(negedge clk);
        ndiff = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== snap[i]) ndiff++;
        total++;
        if (we_tick - w0 !== 0 || re_tick - r0 !== 256 || ndiff !== 0) begin
            bad++;
            $display("FAIL dma_render_drop: we=%0d re=%0d changed=%0d, required 0 256 0",
                     we_tick - w0, re_tick - r0, ndiff);
        end
        total++;
        if (oam_ram_addr !== 8'h20 || ht !== 513) begin
            bad++;
            $display("FAIL dma_render_adv: addr=%h ticks=%0d, required 20 513", oam_ram_addr, ht);
        end
    endtask

    task automatic test_attr_read();
        rendering = 1'b0;
        cpu_wr_addr(8'h02);
        cpu_wr_data(8'hFF);
        cpu_wr_data(8'hFF);
        cpu_wr_addr(8'h02);
        @(negedge clk);
        total++;
        if (reg_rdata !== 8'hE3) begin
            bad++;
            $display("FAIL attr_read: got %h, required E3", reg_rdata);
        end
        repeat (3) @(negedge clk);
        total++;
        if (oam_ram_addr !== 8'h02) begin
            bad++;
            $display("FAIL read_no_inc: got %h, required 02", oam_ram_addr);
        end
        cpu_wr_addr(8'h03);
        @(negedge clk);
        total++;
        if (reg_rdata !== 8'hFF) begin
            bad++;
            $display("FAIL plain_read: got %h, required FF", reg_rdata);
        end
    endtask

    task automatic test_busy_abort();
        int w0, wo0, nw, nerr, n;
        bit halted;
        rendering = 1'b0;
        cpu_wr_addr(8'h40);
        snap = ram;
        w0 = we_tick; wo0 = we_off;
        start_dma(8'h02, 1'b1);
        skip_ticks(29);
        wait_neg_tick();
        dma_start = 1'b1;
        dma_page = 8'h05;
        @(negedge clk);
        dma_start = 1'b0;
        skip_ticks(19);
        cpu_wr_addr(8'hC0);
        cpu_wr_data_off(8'h77);
        skip_ticks(45);
        wait_neg_tick();
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort_in_reset");
        nw = we_tick - w0;
        nerr = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i) + 8'h40;
            if (i < nw) begin
                if (ram[a] !== memf({8'h02, 8'(i)})) nerr++;
            end else if (ram[a] !== snap[a]) begin
                nerr++;
            end
        end
        total++;
        if (nerr !== 0 || nw < 30 || nw > 60 || we_off - wo0 !== 0) begin
            bad++;
            $display("FAIL busy_lockout: bad_bytes=%0d dma_writes=%0d cpu_writes=%0d, required 0 30..60 0",
                     nerr, nw, we_off - wo0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        w0 = we_tick;
        halted = 1'b0;
        n = 0;
        while (n < 90) begin
            @(negedge clk);
            if (cpu_halt || dma_busy) halted = 1'b1;
            n++;
        end
        total++;
        if (halted !== 1'b0 || we_tick - w0 !== 0) begin
            bad++;
            $display("FAIL abort_no_restart: halted=%b writes=%0d, required 0 0", halted, we_tick - w0);
        end
        check_idle_outputs("abort_after_reset");
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_dma(1'b1, 8'h00, 513, "dma_par0");
        test_dma(1'b0, 8'h80, 514, "dma_par1");
        test_rendering_write();
        test_dma_rendering();
        test_attr_read();
        test_busy_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
